cmd_sequencer: RTL and testbench
================================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a program at address 0 when sampled high in IDLE, DONE or ERROR.
REQ-005 cmd_addr  output  8  command-memory word address.
REQ-006 cmd_data  input  32  command-memory read data; valid the cycle after cmd_addr is presented (1-cycle latency).
REQ-007 dut_rst  output  1  active-high reset to the device under test.
REQ-008 init  output  1  one-cycle init strobe to the device.
REQ-009 load  output  1  load request; qualifies idata.
REQ-010 fetch  output  1  fetch request.
REQ-011 idata  output  16  load data, equal to operand bits [15:0].
REQ-012 ack  input  1  device acknowledge for load/fetch.
REQ-013 odata  input  16  device result; sampled in the ack cycle of a fetch.
REQ-014 busy  output  1  high from start acceptance until DONE or ERROR.
REQ-015 done  output  1  high in DONE; held until start or rst.
REQ-016 err_code  output  3  error code: 0 none, 1 unknown opcode, 2 timeout, 3 data mismatch, 4 address wrap.
REQ-017 cycle_count  output  32  count of busy cycles; saturates at FFFFFFFF.

Function
REQ-018 States: IDLE, RD_OP, RD_ARG, EXEC, DONE, ERROR; each word read costs 2 cycles (address, then data).
REQ-019 Opcodes: 1 RESET n; 2 CLOCK p (operand consumed, no operation); 3 INIT; 5 WAITFOR n; 6 LOAD data,timeout,hold; 7 FETCH expect,timeout,hold; FFFFFFFF END.
REQ-020 RESET: dut_rst high for exactly n cycles, with a minimum of 1 cycle when n=0.
REQ-021 INIT: init high for exactly 1 cycle.
REQ-022 WAITFOR: all strobes held at their current value for exactly n cycles; n=0 gives 0 cycles.
REQ-023 LOAD/FETCH request: strobe rises together with entry to EXEC; ack is sampled on every edge while the strobe is high.
REQ-024 Completion: ack sampled high completes the request; timeout occurs when ack is still low after timeout+1 samples (timeout=0 requires ack on the first sample).
REQ-025 FETCH check: odata compared to expect[15:0] in the ack cycle; on inequality, enter ERROR with err_code=3.
REQ-026 hold: hold=0 drops the strobe the cycle after ack; hold!=0 keeps it high into the next command until a LOAD/FETCH with hold=0 completes or END/ERROR is reached.
REQ-027 END: enter DONE, all strobes low, busy=0, done=1.
REQ-028 ERROR: all strobes and dut_rst low; err_code latched; busy=0; state held until start or rst.
REQ-029 Unknown opcode (0, 4 without macro, 8..FFFFFFFE): ERROR with code 1.
REQ-030 Address wrap: a read needed beyond address FF, with no END yet, gives ERROR with code 4.
REQ-031 start while busy is ignored.
REQ-032 start in DONE/ERROR clears err_code, done and cycle_count, then restarts at address 0.
REQ-033 ack while no request is pending is ignored.

Reset
REQ-034 rst wins over every other input at any state, including mid-request.
REQ-035 Next edge after rst: IDLE, cmd_addr=0, all strobes 0, dut_rst=0, idata=0, busy=0, done=0, err_code=0, cycle_count=0.

Configuration
REQ-036 Macro GETCONFIG_EN, when defined, adds output getconfig (1 bit) and opcode 4 GETCONFIG expect,timeout.
REQ-037 With GETCONFIG_EN, opcode 4 behaves as FETCH with hold=0, using getconfig in place of fetch.
REQ-038 Without GETCONFIG_EN, the getconfig port is absent and opcode 4 gives err_code=1.

Verification
REQ-039 Program [1,3, 3, FFFFFFFF] then start -> dut_rst high 3 cycles, then init high 1 cycle, then done=1, err_code=0.
REQ-040 LOAD 00001234,5,0 with ack 2 cycles after load rises -> idata=1234, load drops the cycle after ack; FETCH 1234,5,0 with odata=1234 -> pass.
REQ-041 FETCH 00AB,3,0 with odata=00CD at ack -> err_code=3, fetch low, busy=0.
REQ-042 LOAD x,2,0 with ack tied low -> ERROR code 2 after exactly 3 ack samples.
REQ-043 Opcode 9 -> err_code=1; a 256-word program with no END -> err_code=4.
REQ-044 rst asserted mid-LOAD with hold=1 -> load=0 and IDLE on the next edge; a later start re-executes from address 0.

Source files
------------

// File: rtl/cmd_sequencer_if.sv
// Command-memory read port plus device control/handshake signals of cmd_sequencer.
// Optional getconfig strobe exists only when GETCONFIG_EN is defined.
interface cmd_sequencer_if;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        dut_rst;
    logic        init;
    logic        load;
    logic        fetch;
    logic [15:0] idata;
    logic        ack;
    logic [15:0] odata;
`ifdef GETCONFIG_EN
    logic        getconfig;

    modport master (
        output cmd_addr, dut_rst, init, load, fetch, idata, getconfig,
        input  cmd_data, ack, odata
    );
    modport slave (
        input  cmd_addr, dut_rst, init, load, fetch, idata, getconfig,
        output cmd_data, ack, odata
    );
`else
    modport master (
        output cmd_addr, dut_rst, init, load, fetch, idata,
        input  cmd_data, ack, odata
    );
    modport slave (
        input  cmd_addr, dut_rst, init, load, fetch, idata,
        output cmd_data, ack, odata
    );
`endif
endinterface

// File: rtl/cmd_sequencer.sv
// Command sequencer: reads opcode/operand words from a 1-cycle-latency memory and drives a device.
// Define GETCONFIG_EN to add opcode 4 (GETCONFIG) and the getconfig request strobe.
module cmd_sequencer (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    cmd_sequencer_if.master bus,
    output logic            busy,
    output logic            done,
    output logic [2:0]      err_code,
    output logic [31:0]     cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_OP  = 3'd1;
    localparam logic [2:0] S_RD_ARG = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [2:0] K_RESET  = 3'd0;
    localparam logic [2:0] K_CLOCK  = 3'd1;
    localparam logic [2:0] K_INIT   = 3'd2;
    localparam logic [2:0] K_WAIT   = 3'd3;
    localparam logic [2:0] K_LOAD   = 3'd4;
    localparam logic [2:0] K_FETCH  = 3'd5;

    localparam logic [2:0] E_OPCODE   = 3'd1;
    localparam logic [2:0] E_TIMEOUT  = 3'd2;
    localparam logic [2:0] E_MISMATCH = 3'd3;
    localparam logic [2:0] E_WRAP     = 3'd4;

    localparam int R_LOAD  = 0;
    localparam int R_FETCH = 1;
`ifdef GETCONFIG_EN
    localparam logic [2:0] K_GETCFG = 3'd6;
    localparam int R_GETCFG = 2;
    localparam int NREQ     = 3;
`else
    localparam int NREQ     = 2;
`endif

    logic [2:0]      state_q, state_d;
    logic            phase_q, phase_d;      // 0: address cycle, 1: data cycle
    logic [8:0]      ptr_q, ptr_d;          // bit 8 flags a read past the last word
    logic [2:0]      kind_q, kind_d;
    logic [1:0]      nargs_q, nargs_d;
    logic [1:0]      arg_idx_q, arg_idx_d;
    logic [31:0]     arg0_q, arg0_d, arg1_q, arg1_d, arg2_q, arg2_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            dut_rst_q, dut_rst_d;
    logic            init_q, init_d;
    logic [NREQ-1:0] req_q, req_d;
    logic [15:0]     idata_q, idata_d;
    logic [2:0]      err_q, err_d;
    logic [31:0]     cyc_q, cyc_d;

    logic            dispatch;
    logic            err_hit;
    logic [2:0]      err_val;
    logic            begin_prog;

    assign busy = (state_q == S_RD_OP) || (state_q == S_RD_ARG) || (state_q == S_EXEC);

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        kind_d     = kind_q;
        nargs_d    = nargs_q;
        arg_idx_d  = arg_idx_q;
        arg0_d     = arg0_q;
        arg1_d     = arg1_q;
        arg2_d     = arg2_q;
        cnt_d      = cnt_q;
        dut_rst_d  = dut_rst_q;
        init_d     = init_q;
        req_d      = req_q;
        idata_d    = idata_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        dispatch   = 1'b0;
        err_hit    = 1'b0;
        err_val    = 3'd0;
        begin_prog = 1'b0;

        if (busy && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                begin_prog = start;
            end
            S_RD_OP, S_RD_ARG: begin
                if (!phase_q) begin
                    if (ptr_q[8]) begin
                        err_hit = 1'b1;
                        err_val = E_WRAP;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    phase_d = 1'b0;
                    ptr_d   = ptr_q + 9'd1;
                    if (state_q == S_RD_OP) begin
                        state_d   = S_RD_ARG;
                        arg_idx_d = 2'd0;
                        case (bus.cmd_data)
                            32'd1: begin kind_d = K_RESET; nargs_d = 2'd1; end
                            32'd2: begin kind_d = K_CLOCK; nargs_d = 2'd1; end
                            32'd3: begin kind_d = K_INIT;  dispatch = 1'b1; end
                            32'd5: begin kind_d = K_WAIT;  nargs_d = 2'd1; end
                            32'd6: begin kind_d = K_LOAD;  nargs_d = 2'd3; end
                            32'd7: begin kind_d = K_FETCH; nargs_d = 2'd3; end
`ifdef GETCONFIG_EN
                            // GETCONFIG has no hold operand; a cleared hold makes it drop after ack.
                            32'd4: begin kind_d = K_GETCFG; nargs_d = 2'd2; arg2_d = 32'd0; end
`endif
                            32'hFFFF_FFFF: begin
                                state_d = S_DONE;
                                req_d   = '0;
                            end
                            default: begin
                                err_hit = 1'b1;
                                err_val = E_OPCODE;
                            end
                        endcase
                    end else begin
                        case (arg_idx_q)
                            2'd0:    arg0_d = bus.cmd_data;
                            2'd1:    arg1_d = bus.cmd_data;
                            default: arg2_d = bus.cmd_data;
                        endcase
                        if (arg_idx_q == nargs_q - 2'd1) begin
                            dispatch = 1'b1;
                        end else begin
                            arg_idx_d = arg_idx_q + 2'd1;
                        end
                    end
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_RESET, K_WAIT: begin
                        if (cnt_q == 32'd1) begin
                            dut_rst_d = 1'b0;
                            state_d   = S_RD_OP;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                    K_INIT: begin
                        init_d  = 1'b0;
                        state_d = S_RD_OP;
                    end
                    default: begin
                        if (bus.ack) begin
                            if ((kind_q != K_LOAD) && (bus.odata != arg0_q[15:0])) begin
                                err_hit = 1'b1;
                                err_val = E_MISMATCH;
                            end else begin
                                state_d = S_RD_OP;
                                if (arg2_q == 32'd0) begin
                                    req_d = '0;
                                end
                            end
                        end else if (cnt_q == 32'd0) begin
                            err_hit = 1'b1;
                            err_val = E_TIMEOUT;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        // CLOCK and WAITFOR 0 fall straight through to the next opcode read.
        if (dispatch) begin
            state_d = S_RD_OP;
            case (kind_d)
                K_RESET: begin
                    state_d   = S_EXEC;
                    dut_rst_d = 1'b1;
                    cnt_d     = (arg0_d == 32'd0) ? 32'd1 : arg0_d;
                end
                K_INIT: begin
                    state_d = S_EXEC;
                    init_d  = 1'b1;
                end
                K_WAIT: begin
                    if (arg0_d != 32'd0) begin
                        state_d = S_EXEC;
                        cnt_d   = arg0_d;
                    end
                end
                K_LOAD: begin
                    state_d       = S_EXEC;
                    req_d[R_LOAD] = 1'b1;
                    idata_d       = arg0_d[15:0];
                    cnt_d         = arg1_d;
                end
                K_FETCH: begin
                    state_d        = S_EXEC;
                    req_d[R_FETCH] = 1'b1;
                    cnt_d          = arg1_d;
                end
`ifdef GETCONFIG_EN
                K_GETCFG: begin
                    state_d         = S_EXEC;
                    req_d[R_GETCFG] = 1'b1;
                    cnt_d           = arg1_d;
                end
`endif
                default: ;
            endcase
        end

        if (err_hit) begin
            state_d   = S_ERROR;
            err_d     = err_val;
            dut_rst_d = 1'b0;
            init_d    = 1'b0;
            req_d     = '0;
        end

        if (begin_prog) begin
            state_d = S_RD_OP;
            phase_d = 1'b0;
            ptr_d   = 9'd0;
            err_d   = 3'd0;
            cyc_d   = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples the pre-edge values.
        if (rst) begin
            // NOTE: operand and counter registers are reset too, so no X can leak onto outputs.
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            ptr_q     <= 9'd0;
            kind_q    <= K_RESET;
            nargs_q   <= 2'd0;
            arg_idx_q <= 2'd0;
            arg0_q    <= 32'd0;
            arg1_q    <= 32'd0;
            arg2_q    <= 32'd0;
            cnt_q     <= 32'd0;
            dut_rst_q <= 1'b0;
            init_q    <= 1'b0;
            req_q     <= '0;
            idata_q   <= 16'd0;
            err_q     <= 3'd0;
            cyc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ptr_q     <= ptr_d;
            kind_q    <= kind_d;
            nargs_q   <= nargs_d;
            arg_idx_q <= arg_idx_d;
            arg0_q    <= arg0_d;
            arg1_q    <= arg1_d;
            arg2_q    <= arg2_d;
            cnt_q     <= cnt_d;
            dut_rst_q <= dut_rst_d;
            init_q    <= init_d;
            req_q     <= req_d;
            idata_q   <= idata_d;
            err_q     <= err_d;
            cyc_q     <= cyc_d;
        end
    end

    assign bus.cmd_addr  = ptr_q[7:0];
    assign bus.dut_rst   = dut_rst_q;
    assign bus.init      = init_q;
    assign bus.load      = req_q[R_LOAD];
    assign bus.fetch     = req_q[R_FETCH];
    assign bus.idata     = idata_q;
`ifdef GETCONFIG_EN
    assign bus.getconfig = req_q[R_GETCFG];
`endif
    assign done        = (state_q == S_DONE);
    assign err_code    = err_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed self-checking bench for cmd_sequencer; C<k> denotes the k-th cycle after start is accepted.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;
    logic [31:0] cycle_count;

    logic [31:0] mem [256];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          rst_cnt, rst_first, init_cnt, init_first, init_last, done_at;

    cmd_sequencer_if bus ();

    cmd_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Command memory with one cycle of read latency.
    always @(posedge clk) bus.cmd_data <= mem[bus.cmd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic start_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc        = 1;
        rst_cnt    = 0;
        rst_first  = 0;
        init_cnt   = 0;
        init_first = 0;
        init_last  = 0;
        done_at    = 0;
    endtask

    task automatic observe(input int n);
        while (cyc < n) begin
            tick();
            if (bus.dut_rst) begin
                rst_cnt++;
                if (rst_first == 0) rst_first = cyc;
            end
            if (bus.init) begin
                init_cnt++;
                if (init_first == 0) init_first = cyc;
                init_last = cyc;
            end
            if (done && done_at == 0) done_at = cyc;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bus.ack   = 1'b0;
        bus.odata = 16'h0;
        clear_mem();
        tick();
        tick();
        check("rst_addr",   {24'h0, bus.cmd_addr}, 32'h0);
        check("rst_strobe", {28'h0, bus.dut_rst, bus.init, bus.load, bus.fetch}, 32'h0);
        check("rst_idata",  {16'h0, bus.idata}, 32'h0);
        check("rst_status", {28'h0, busy, done, 2'b00}, 32'h0);
        check("rst_err",    {29'h0, err_code}, 32'h0);
        check("rst_cycles", cycle_count, 32'h0);
        rst = 1'b0;
        tick();

        // RESET 3, INIT, END
        clear_mem();
        mem[0] = 32'd1; mem[1] = 32'd3; mem[2] = 32'd3; mem[3] = 32'hFFFF_FFFF;
        start_prog();
        check("p1_busy_c1", {31'h0, busy}, 32'h1);
        observe(20);
        check("p1_rst_cnt",   rst_cnt, 32'd3);
        check("p1_rst_first", rst_first, 32'd5);
        check("p1_init_cnt",  init_cnt, 32'd1);
        check("p1_init_at",   init_first, 32'd10);
        check("p1_done_at",   done_at, 32'd13);
        check("p1_done",      {31'h0, done}, 32'h1);
        check("p1_busy",      {31'h0, busy}, 32'h0);
        check("p1_err",       {29'h0, err_code}, 32'h0);
        check("p1_cycles",    cycle_count, 32'd12);

        // RESET 0, WAITFOR 2, INIT, CLOCK 7, WAITFOR 0, INIT, END (restart from DONE)
        clear_mem();
        mem[0] = 32'd1; mem[1] = 32'd0; mem[2] = 32'd5; mem[3] = 32'd2;
        mem[4] = 32'd3; mem[5] = 32'd2; mem[6] = 32'd7; mem[7] = 32'd5;
        mem[8] = 32'd0; mem[9] = 32'd3; mem[10] = 32'hFFFF_FFFF;
        start_prog();
        check("p2_done_clr",  {31'h0, done}, 32'h0);
        check("p2_cyc_clr",   cycle_count, 32'h0);
        observe(30);
        check("p2_rst_cnt",   rst_cnt, 32'd1);
        check("p2_rst_first", rst_first, 32'd5);
        check("p2_init_cnt",  init_cnt, 32'd2);
        check("p2_init_first", init_first, 32'd14);
        check("p2_init_last", init_last, 32'd25);
        check("p2_done_at",   done_at, 32'd28);

        // LOAD 1234,5,0 then FETCH 1234,5,0 with ack held high across the reads
        clear_mem();
        mem[0] = 32'd6; mem[1] = 32'h0000_1234; mem[2] = 32'd5; mem[3] = 32'd0;
        mem[4] = 32'd7; mem[5] = 32'h0000_1234; mem[6] = 32'd5; mem[7] = 32'd0;
        mem[8] = 32'hFFFF_FFFF;
        start_prog();
        goto(8);
        check("p3_load_c8", {31'h0, bus.load}, 32'h0);
        goto(9);
        check("p3_load_c9", {31'h0, bus.load}, 32'h1);
        check("p3_idata",   {16'h0, bus.idata}, 32'h1234);
        goto(11);
        bus.ack = 1'b1;
        check("p3_load_c11", {31'h0, bus.load}, 32'h1);
        goto(12);
        bus.ack = 1'b0;
        check("p3_load_drop", {31'h0, bus.load}, 32'h0);
        goto(14);
        bus.ack   = 1'b1;
        bus.odata = 16'h1234;
        goto(19);
        check("p3_fetch_c19", {31'h0, bus.fetch}, 32'h0);
        goto(20);
        check("p3_fetch_c20", {31'h0, bus.fetch}, 32'h1);
        goto(21);
        bus.ack = 1'b0;
        check("p3_fetch_drop", {31'h0, bus.fetch}, 32'h0);
        goto(23);
        check("p3_done",   {31'h0, done}, 32'h1);
        check("p3_err",    {29'h0, err_code}, 32'h0);
        check("p3_cycles", cycle_count, 32'd22);

        // FETCH 00AB,3,0 answered with 00CD
        clear_mem();
        mem[0] = 32'd7; mem[1] = 32'h0000_00AB; mem[2] = 32'd3; mem[3] = 32'd0;
        mem[4] = 32'hFFFF_FFFF;
        start_prog();
        goto(9);
        check("p4_fetch", {31'h0, bus.fetch}, 32'h1);
        bus.ack   = 1'b1;
        bus.odata = 16'h00CD;
        goto(10);
        bus.ack = 1'b0;
        check("p4_err",    {29'h0, err_code}, 32'd3);
        check("p4_fetch0", {31'h0, bus.fetch}, 32'h0);
        check("p4_busy",   {31'h0, busy}, 32'h0);
        check("p4_cycles", cycle_count, 32'd9);

        // LOAD x,2,0 with ack low: timeout after the third sample
        clear_mem();
        mem[0] = 32'd6; mem[1] = 32'h0000_5555; mem[2] = 32'd2; mem[3] = 32'd0;
        mem[4] = 32'hFFFF_FFFF;
        start_prog();
        check("p5_err_clr", {29'h0, err_code}, 32'h0);
        goto(11);
        check("p5_load_c11", {31'h0, bus.load}, 32'h1);
        check("p5_err_c11",  {29'h0, err_code}, 32'h0);
        goto(12);
        check("p5_err",   {29'h0, err_code}, 32'd2);
        check("p5_load0", {31'h0, bus.load}, 32'h0);
        check("p5_busy",  {31'h0, busy}, 32'h0);

        // LOAD hold=1 stays high through WAITFOR 3 until a hold=0 LOAD completes
        clear_mem();
        mem[0] = 32'd6; mem[1] = 32'h0000_BEEF; mem[2] = 32'd4; mem[3] = 32'd1;
        mem[4] = 32'd5; mem[5] = 32'd3;
        mem[6] = 32'd6; mem[7] = 32'h0000_0042; mem[8] = 32'd4; mem[9] = 32'd0;
        mem[10] = 32'hFFFF_FFFF;
        start_prog();
        goto(9);
        bus.ack = 1'b1;
        goto(10);
        bus.ack = 1'b0;
        check("p6_hold_c10", {31'h0, bus.load}, 32'h1);
        goto(15);
        bus.ack = 1'b1;
        goto(16);
        bus.ack = 1'b0;
        check("p6_hold_c16", {31'h0, bus.load}, 32'h1);
        check("p6_idata1",   {16'h0, bus.idata}, 32'hBEEF);
        goto(25);
        check("p6_load_c25", {31'h0, bus.load}, 32'h1);
        check("p6_idata2",   {16'h0, bus.idata}, 32'h0042);
        bus.ack = 1'b1;
        goto(26);
        bus.ack = 1'b0;
        check("p6_load_drop", {31'h0, bus.load}, 32'h0);
        goto(28);
        check("p6_done", {31'h0, done}, 32'h1);

        // Unknown opcode 9
        clear_mem();
        mem[0] = 32'd9;
        start_prog();
        goto(2);
        check("p7_busy_c2", {31'h0, busy}, 32'h1);
        goto(3);
        check("p7_err",  {29'h0, err_code}, 32'd1);
        check("p7_busy", {31'h0, busy}, 32'h0);

`ifdef GETCONFIG_EN
        // GETCONFIG 77,1 behaves as FETCH with hold=0
        clear_mem();
        mem[0] = 32'd4; mem[1] = 32'h0000_0077; mem[2] = 32'd1; mem[3] = 32'hFFFF_FFFF;
        start_prog();
        goto(7);
        check("p8_getcfg", {31'h0, bus.getconfig}, 32'h1);
        bus.ack   = 1'b1;
        bus.odata = 16'h0077;
        goto(8);
        bus.ack = 1'b0;
        check("p8_getcfg_drop", {31'h0, bus.getconfig}, 32'h0);
        goto(10);
        check("p8_done", {31'h0, done}, 32'h1);
`else
        // Opcode 4 is unknown without the GETCONFIG option
        clear_mem();
        mem[0] = 32'd4;
        start_prog();
        goto(3);
        check("p8_op4_err", {29'h0, err_code}, 32'd1);
`endif

        // 256 INIT words with no END: address wrap
        for (int i = 0; i < 256; i++) mem[i] = 32'd3;
        start_prog();
        goto(769);
        check("p9_busy_c769", {31'h0, busy}, 32'h1);
        check("p9_err_c769",  {29'h0, err_code}, 32'h0);
        goto(770);
        check("p9_err",    {29'h0, err_code}, 32'd4);
        check("p9_busy",   {31'h0, busy}, 32'h0);
        check("p9_cycles", cycle_count, 32'd769);

        // rst mid-LOAD with hold=1, then restart from address 0 with a stray start mid-run
        clear_mem();
        mem[0] = 32'd6; mem[1] = 32'h0000_1111; mem[2] = 32'd9; mem[3] = 32'd1;
        mem[4] = 32'd3; mem[5] = 32'hFFFF_FFFF;
        start_prog();
        goto(10);
        check("p10_load_pre", {31'h0, bus.load}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("p10_rst_load",  {31'h0, bus.load}, 32'h0);
        check("p10_rst_busy",  {31'h0, busy}, 32'h0);
        check("p10_rst_addr",  {24'h0, bus.cmd_addr}, 32'h0);
        check("p10_rst_idata", {16'h0, bus.idata}, 32'h0);
        start_prog();
        check("p10_addr_c1", {24'h0, bus.cmd_addr}, 32'h0);
        goto(5);
        start = 1'b1;
        goto(6);
        start = 1'b0;
        goto(9);
        check("p10_load_c9", {31'h0, bus.load}, 32'h1);
        check("p10_idata",   {16'h0, bus.idata}, 32'h1111);
        bus.ack = 1'b1;
        goto(10);
        bus.ack = 1'b0;
        goto(15);
        check("p10_done",  {31'h0, done}, 32'h1);
        check("p10_load0", {31'h0, bus.load}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
